// File: rtl/srff_excite_driver.sv
// Drives an attached clocked SR flip-flop toward a stream of target bits and
// checks the flop's q/qbar a fixed number of cycles after each excitation pulse.
module srff_excite_driver #(
  parameter int CHECK_DELAY = 1,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             s,
  output logic             r,
  input  logic             q,
  input  logic             qbar,
  output logic             busy,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      vec_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK
  } state_e;

  localparam logic [3:0]       WAIT_LOAD = 4'(CHECK_DELAY - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic             tgt_r_q, tgt_r_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [15:0]      vec_count_q, vec_count_d;
  logic             match;
  logic             mismatch;

  always_comb begin
    state_d     = state_q;
    tgt_r_d     = tgt_r_q;
    s_d         = 1'b0;
    r_d         = 1'b0;
    cnt_d       = cnt_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    vec_count_d = vec_count_q;

    // Written as an if so an unknown q/qbar falls through to a mismatch.
    match    = (q == tgt_r_q) && (qbar == ~q);
    mismatch = 1'b1;
    if (match) begin
      mismatch = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (tgt_valid) begin
          tgt_r_d = tgt_bit;
          s_d     = ~q & tgt_bit;
          r_d     = q & ~tgt_bit;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d   = WAIT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        err_pulse_d = mismatch;
        if (mismatch && (err_count_q != ERR_MAX)) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
        vec_count_d = vec_count_q + 16'd1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tgt_r_q     <= 1'b0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      cnt_q       <= 4'd0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      vec_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      tgt_r_q     <= tgt_r_d;
      s_q         <= s_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      vec_count_q <= vec_count_d;
    end
  end

  assign tgt_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign s         = s_q;
  assign r         = r_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_srff_excite_driver.sv
// Scoreboard bench for srff_excite_driver: a behavioural SR flop with fault
// injection closes the loop, accepts push expectations, a monitor checks them.
module tb_srff_excite_driver;

  localparam int CD = 1;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tgt_valid = 1'b0;
  logic          tgt_bit = 1'b0;
  logic          tgt_ready;
  logic          s;
  logic          r;
  logic          q_in;
  logic          qbar_in;
  logic          busy;
  logic          err_pulse;
  logic [EW-1:0] err_count;
  logic [15:0]   vec_count;

  srff_excite_driver #(
    .CHECK_DELAY(CD),
    .ERR_W      (EW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tgt_valid(tgt_valid),
    .tgt_bit  (tgt_bit),
    .tgt_ready(tgt_ready),
    .s        (s),
    .r        (r),
    .q        (q_in),
    .qbar     (qbar_in),
    .busy     (busy),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // Behavioural SR flop; fault_mode 1 sticks q at 0, mode 2 forces q=qbar=1
  logic qreg;
  int   fault_mode = 0;

  always @(posedge clk) begin
    if (rst) qreg <= 1'b0;
    else if (s) qreg <= 1'b1;
    else if (r) qreg <= 1'b0;
  end

  assign q_in    = (fault_mode == 1) ? 1'b0 : (fault_mode == 2) ? 1'b1 : qreg;
  assign qbar_in = (fault_mode == 2) ? 1'b1 : ~q_in;

  typedef struct {
    logic s;
    logic r;
    logic mis;
    logic chk_gap;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   stim_timeouts = 0;
  bit   done = 1'b0;
  bit   held_check = 1'b0;
  bit   rst_at_edge = 1'b0;

  // Reference: on accept, drive toward the target only if the flop differs
  // from it; expect a mismatch only when a fault keeps the flop off target.
  always @(posedge clk) begin
    exp_t e;
    rst_at_edge = rst;
    if (!rst && tgt_valid && tgt_ready) begin
      e.s       = 1'b0;
      e.r       = 1'b0;
      if (q_in != tgt_bit) begin
        e.s = tgt_bit;
        e.r = !tgt_bit;
      end
      case (fault_mode)
        1:       e.mis = (tgt_bit != 1'b0);
        2:       e.mis = 1'b1;
        default: e.mis = 1'b0;
      endcase
      e.chk_gap = held_check;
      exp_q.push_back(e);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per completed target
  exp_t        cur;
  bit          prev_busy = 1'b0;
  int          busy_len = 0;
  int          idle_len = 99;
  int          model_err = 0;
  logic [15:0] model_vec = 16'd0;

  always @(negedge clk) begin
    if (done) begin
      checkOutput("stimulus_timeouts", stim_timeouts, 0);
      checkOutput("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end else if (rst_at_edge) begin
      exp_q.delete();
      model_err = 0;
      model_vec = 16'd0;
      prev_busy = 1'b0;
      idle_len  = 99;
      checkOutput("rst_tgt_ready", tgt_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_s", s, 0);
      checkOutput("rst_r", r, 0);
      checkOutput("rst_err_pulse", err_pulse, 0);
      checkOutput("rst_err_count", err_count, 0);
      checkOutput("rst_vec_count", vec_count, 0);
    end else begin
      checkOutput("s_and_r", s & r, 0);
      checkOutput("ready_vs_busy", tgt_ready, !busy);
      if (busy && !prev_busy) begin
        checkOutput("pending_at_drive", exp_q.size() != 0, 1);
        checkOutput("err_pulse_drive", err_pulse, 0);
        if (exp_q.size() != 0) begin
          cur = exp_q[0];
          checkOutput("drive_s", s, cur.s);
          checkOutput("drive_r", r, cur.r);
          if (cur.chk_gap) checkOutput("idle_gap", idle_len, 1);
        end
        busy_len = 1;
      end else if (busy) begin
        busy_len++;
        checkOutput("sr_after_drive", {s, r}, 0);
        checkOutput("err_pulse_busy", err_pulse, 0);
      end else if (prev_busy) begin
        checkOutput("sr_idle", {s, r}, 0);
        checkOutput("busy_len", busy_len, CD + 2);
        checkOutput("pending_at_done", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          model_vec = model_vec + 16'd1;
          if (cur.mis && model_err < (2 ** EW) - 1) model_err++;
          checkOutput("err_pulse", err_pulse, cur.mis);
          checkOutput("err_count", err_count, model_err);
          checkOutput("vec_count", vec_count, model_vec);
        end
        idle_len = 1;
      end else begin
        checkOutput("sr_idle", {s, r}, 0);
        checkOutput("err_pulse_quiet", err_pulse, 0);
        idle_len++;
      end
      prev_busy = busy;
    end
  end

  // Offer one target; optionally wiggle valid/bit while the driver is busy
  task automatic applyStimulus(input logic b, input int gap, input bit noisy);
    int n;
    if (gap > 0) begin
      tgt_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    if (noisy) begin
      n = 0;
      while (busy && n < 100) begin
        tgt_valid = 1'($urandom_range(0, 1));
        tgt_bit   = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
    end
    tgt_valid = 1'b1;
    tgt_bit   = b;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!(tgt_ready && !rst) && n < 100);
    if (!(tgt_ready && !rst)) begin
      stim_timeouts++;
      $display("[TB] FAIL accept_timeout: no accept within %0d cycles", n);
    end
    @(negedge clk);
  endtask

  task automatic waitIdle();
    int n;
    tgt_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      stim_timeouts++;
      $display("[TB] FAIL idle_timeout: still busy after %0d cycles", n);
    end
  endtask

  logic seq_bits[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int   mode;

  // Directed scenarios first, then a randomized run with occasional faults
  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, 1, 1'b0);
    waitIdle();
    applyStimulus(1'b0, 1, 1'b0);
    waitIdle();

    for (int i = 0; i < 5; i++) begin
      held_check = (i > 0);
      applyStimulus(seq_bits[i], 0, 1'b0);
    end
    held_check = 1'b0;
    waitIdle();

    fault_mode = 1;
    applyStimulus(1'b1, 1, 1'b0);
    waitIdle();
    fault_mode = 2;
    applyStimulus(1'b1, 1, 1'b0);
    waitIdle();
    fault_mode = 0;

    applyStimulus(1'($urandom_range(0, 1)), 1, 1'b0);
    tgt_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1, 1'b0);
    waitIdle();

    fault_mode = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 0, 1'b0);
    end
    waitIdle();
    fault_mode = 0;

    for (int i = 0; i < 40; i++) begin
      mode = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (mode != fault_mode) begin
        waitIdle();
        fault_mode = mode;
      end
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)));
    end
    waitIdle();
    fault_mode = 0;
    repeat (3) @(negedge clk);
    done = 1'b1;
    repeat (10) @(negedge clk);
    $display("[TB] FAIL monitor_finish: monitor did not end the run");
    $fatal(1, "[TB] monitor did not finish");
  end

endmodule
